int_div_seq: RTL and testbench

- Parametrised sequential integer divider; successor to the fixed 32-bit divider.
- Radix-2 restoring algorithm, one quotient bit per cycle.
- Adds: configurable width, per-operation signed/unsigned mode, valid/ready handshakes on both sides, divide-by-zero and signed-overflow flags, and a correctly signed remainder.
- Sits beside the ALU as a multi-cycle execution unit.

---
 rtl/int_div_pkg.sv | 43 ++++
 rtl/int_div_step.sv | 33 +++
 rtl/int_div_seq.sv | 149 ++++++++++++++
 tb/tb_int_div_seq.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/int_div_pkg.sv
// Shared definitions for the sequential integer divider.
//
// Contents:
//   state_t  - divider FSM state (IDLE, CALC, FIX, DONE), 2-bit encoding
//   word_t   - widest operand the helper functions handle (MAX_W bits)
//   abs_val  - two's-complement magnitude of a width-bit value when signed
//   neg_if   - conditional two's-complement negation
//
// The helpers work on MAX_W-bit words so one package serves every divider
// width. Callers zero-extend their operand into a word_t and size-cast the
// result back. Only the low 'width' bits of a result are meaningful, so
// WIDTH must not exceed MAX_W.
package int_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int MAX_W = 64;

    typedef logic [MAX_W-1:0] word_t;

    // Magnitude of a width-bit value. In unsigned mode the value is returned
    // untouched. In signed mode the most negative value maps to
    // 2^(width-1), which still fits in width unsigned bits.
    function automatic word_t abs_val(input word_t value, input logic is_signed,
                                      input int unsigned width);
        word_t sign_mask;
        sign_mask = word_t'(1) << (width - 1);
        if (is_signed && ((value & sign_mask) != '0)) begin
            return ~value + word_t'(1);
        end
        return value;
    endfunction

    function automatic word_t neg_if(input word_t value, input logic cond);
        return cond ? (~value + word_t'(1)) : value;
    endfunction

endpackage

// File: rtl/int_div_step.sv
// One radix-2 restoring-division iteration (purely combinational).
//
// Ports:
//   rem_in       [WIDTH:0]   partial remainder before this step
//   dividend_msb             next dividend bit shifted into the remainder
//   divisor_mag  [WIDTH-1:0] unsigned divisor magnitude
//   rem_out      [WIDTH:0]   partial remainder after this step
//   q_bit                    quotient bit produced by this step
//
// Invariant: rem_in < divisor_mag. The shifted remainder is therefore below
// 2^(WIDTH+1). One extra bit on the trial difference acts as its sign.
module int_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             dividend_msb,
    input  logic [WIDTH-1:0] divisor_mag,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    assign shifted = {rem_in, dividend_msb};
    assign diff    = shifted - {2'b00, divisor_mag};

    // A borrow out of the trial subtraction means the divisor did not fit.
    // In that case the shifted value is kept unchanged (the restore).
    assign q_bit   = ~diff[WIDTH+1];
    assign rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/int_div_seq.sv
// Sequential radix-2 restoring integer divider with valid/ready handshakes.
// Produces one quotient bit per cycle. Signed mode truncates toward zero,
// and the remainder takes the sign of the dividend.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready    operation request handshake
//   in_signed              1 = two's-complement operands, 0 = unsigned
//   dividend, divisor      operands, sampled only at accept
//   out_valid / out_ready  result handshake
//   quotient, remainder    result, held until the next result overwrites it
//   div_by_zero, overflow  status flags, qualified by out_valid
//
// Sequence: IDLE -> CALC (WIDTH cycles) -> FIX (sign correction) -> DONE.
// A zero divisor skips straight from IDLE to DONE.
module int_div_seq
    import int_div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH:0]   rem_reg;
    // Holds the dividend magnitude at first. It shifts left one bit per
    // step, and the new quotient bit enters at the bottom, so after WIDTH
    // steps it holds the unsigned quotient.
    logic [WIDTH-1:0] dvd_reg;
    logic [WIDTH-1:0] dsr_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic             ovf_reg;

    logic             accept;
    logic             zero_divisor;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dsr_mag;
    logic [WIDTH:0]   step_rem;
    logic             step_q;

    assign in_ready     = (state_reg == IDLE);
    assign out_valid    = (state_reg == DONE);
    assign accept       = in_valid && in_ready;
    assign zero_divisor = (divisor == '0);
    assign dvd_mag      = WIDTH'(abs_val(word_t'(dividend), in_signed, WIDTH));
    assign dsr_mag      = WIDTH'(abs_val(word_t'(divisor), in_signed, WIDTH));

    int_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_in      (rem_reg),
        .dividend_msb(dvd_reg[WIDTH-1]),
        .divisor_mag (dsr_reg),
        .rem_out     (step_rem),
        .q_bit       (step_q)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: if (accept) state_next = zero_divisor ? DONE : CALC;
            CALC: if (cnt_reg == '0) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg     <= '0;
            rem_reg     <= '0;
            dvd_reg     <= '0;
            dsr_reg     <= '0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            ovf_reg     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        neg_q_reg <= in_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r_reg <= in_signed && dividend[WIDTH-1];
                        ovf_reg   <= in_signed && (dividend == MIN_VAL) && (divisor == '1);
                        dvd_reg   <= dvd_mag;
                        dsr_reg   <= dsr_mag;
                        rem_reg   <= '0;
                        cnt_reg   <= CNT_W'(WIDTH - 1);
                        if (zero_divisor) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    rem_reg <= step_rem;
                    dvd_reg <= {dvd_reg[WIDTH-2:0], step_q};
                    cnt_reg <= cnt_reg - 1'b1;
                end
                FIX: begin
                    // MIN / -1 needs no special path. The magnitude quotient
                    // 2^(WIDTH-1) is not negated because both signs are set,
                    // so it reads back as MIN.
                    quotient    <= WIDTH'(neg_if(word_t'(dvd_reg), neg_q_reg));
                    remainder   <= WIDTH'(neg_if(word_t'(rem_reg[WIDTH-1:0]), neg_r_reg));
                    div_by_zero <= 1'b0;
                    overflow    <= ovf_reg;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_div_seq.sv
module tb_int_div_seq;

    typedef longint unsigned u64_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          s;
        logic [31:0] q;
        logic [31:0] r;
        bit          dz;
        bit          ov;
        int          lat;   // clock edges after the accept edge until out_valid is seen
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        iv32, ir32, is32, ovl32, or32, dz32, of32;
    logic [31:0] dd32, ds32, q32, r32;
    logic        iv8, ir8, is8, ovl8, or8, dz8, of8;
    logic [7:0]  dd8, ds8, q8, r8;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    int_div_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv32), .in_ready(ir32), .in_signed(is32),
        .dividend(dd32), .divisor(ds32),
        .out_valid(ovl32), .out_ready(or32),
        .quotient(q32), .remainder(r32),
        .div_by_zero(dz32), .overflow(of32)
    );

    int_div_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8), .in_signed(is8),
        .dividend(dd8), .divisor(ds8),
        .out_valid(ovl8), .out_ready(or8),
        .quotient(q8), .remainder(r8),
        .div_by_zero(dz8), .overflow(of8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: plain integer arithmetic on w-bit operands.
    function automatic void ref_div(input u64_t a_in, input u64_t b_in, input bit s,
                                    input int w, output u64_t q, output u64_t r,
                                    output bit dz, output bit ov);
        u64_t mask, minv, a, b;
        longint sa, sb;
        mask = (u64_t'(1) << w) - u64_t'(1);
        minv = u64_t'(1) << (w - 1);
        a = a_in & mask;
        b = b_in & mask;
        dz = (b == 0);
        ov = 1'b0;
        if (dz) begin
            q = mask;
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = (a >= minv) ? longint'(a) - longint'(mask) - 1 : longint'(a);
            sb = (b >= minv) ? longint'(b) - longint'(mask) - 1 : longint'(b);
            q = u64_t'(sa / sb) & mask;
            r = u64_t'(sa % sb) & mask;
            ov = (a == minv) && (b == mask);
        end
    endfunction

    // Issue one operation on the selected instance, wait for the result,
    // optionally stall out_ready for 'hold' cycles, then complete it.
    task automatic run_op(input bit w8, input logic [31:0] a, input logic [31:0] b,
                          input bit s, input int hold,
                          output logic [31:0] q, output logic [31:0] r,
                          output bit dz, output bit ov, output int lat);
        int n;
        lat = -1;
        q = '0; r = '0; dz = 1'b0; ov = 1'b0;
        if (w8) begin iv8 = 1'b1; dd8 = a[7:0]; ds8 = b[7:0]; is8 = s; end
        else begin iv32 = 1'b1; dd32 = a; ds32 = b; is32 = s; end
        n = 0;
        while (!(w8 ? ir8 : ir32) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        // Inputs change after accept; the result must not depend on them.
        if (w8) begin iv8 = 1'b0; dd8 = 8'($urandom); ds8 = 8'($urandom); is8 = 1'($urandom); end
        else begin iv32 = 1'b0; dd32 = $urandom; ds32 = $urandom; is32 = 1'($urandom); end
        for (int c = 0; c < 200; c++) begin
            if (w8 ? ovl8 : ovl32) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        repeat (hold) begin @(posedge clk); #1; end
        if (w8) begin q = {24'd0, q8}; r = {24'd0, r8}; dz = dz8; ov = of8; or8 = 1'b1; end
        else begin q = q32; r = r32; dz = dz32; ov = of32; or32 = 1'b1; end
        @(posedge clk); #1;
        or8 = 1'b0;
        or32 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[12];
        logic [31:0] q, r, sq, sr, a, b;
        bit          dz, ov, ok, s;
        int          lat, n, hold;
        u64_t        eq, er;
        bit          edz, eov;

        vecs[0]  = '{32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         1'b0, 1'b0, 33};
        vecs[1]  = '{32'hFFFFFF9C,  32'd7,         1'b1, 32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0, 1'b0, 33};
        vecs[2]  = '{32'd100,       32'hFFFFFFF9,  1'b1, 32'hFFFFFFF2,  32'd2,         1'b0, 1'b0, 33};
        // Zero divisor: out_valid is already high in the cycle after accept.
        vecs[3]  = '{32'd7,         32'd0,         1'b0, 32'hFFFFFFFF,  32'd7,         1'b1, 1'b0, 0};
        vecs[4]  = '{32'd7,         32'd0,         1'b1, 32'hFFFFFFFF,  32'd7,         1'b1, 1'b0, 0};
        vecs[5]  = '{32'h80000000,  32'hFFFFFFFF,  1'b1, 32'h80000000,  32'd0,         1'b0, 1'b1, 33};
        vecs[6]  = '{32'hFFFFFFFF,  32'd1,         1'b0, 32'hFFFFFFFF,  32'd0,         1'b0, 1'b0, 33};
        vecs[7]  = '{32'hFFFFFFFF,  32'd1,         1'b1, 32'hFFFFFFFF,  32'd0,         1'b0, 1'b0, 33};
        vecs[8]  = '{32'd0,         32'd5,         1'b0, 32'd0,         32'd0,         1'b0, 1'b0, 33};
        vecs[9]  = '{32'd5,         32'd9,         1'b0, 32'd0,         32'd5,         1'b0, 1'b0, 33};
        vecs[10] = '{32'h80000000,  32'hFFFFFFFF,  1'b0, 32'd0,         32'h80000000,  1'b0, 1'b0, 33};
        vecs[11] = '{32'hFFFFFFF9,  32'd2,         1'b1, 32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0, 1'b0, 33};

        iv32 = 0; is32 = 0; dd32 = 0; ds32 = 0; or32 = 0;
        iv8 = 0; is8 = 0; dd8 = 0; ds8 = 0; or8 = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", ir32, 1);
        chk("reset_out_valid", ovl32, 0);
        chk("reset_quotient", q32, 0);
        chk("reset_remainder", r32, 0);
        chk("reset_flags", {dz32, of32}, 0);
        @(negedge clk) rst_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            run_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].s, 0, q, r, dz, ov, lat);
            $display("vec %0d: %h / %h s=%0b -> q=%h r=%h dz=%0b ov=%0b lat=%0d",
                     i, vecs[i].a, vecs[i].b, vecs[i].s, q, r, dz, ov, lat);
            chk($sformatf("vec%0d_q", i), q, vecs[i].q);
            chk($sformatf("vec%0d_r", i), r, vecs[i].r);
            chk($sformatf("vec%0d_dz", i), dz, vecs[i].dz);
            chk($sformatf("vec%0d_ov", i), ov, vecs[i].ov);
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
        end

        // Stall in DONE for 10 cycles, then release and accept back-to-back.
        @(negedge clk);
        dd32 = 32'd50; ds32 = 32'd3; is32 = 1'b0; iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        n = 0;
        while (!ovl32 && n < 100) begin @(posedge clk); #1; n++; end
        chk("stall_reach_done", ovl32, 1);
        sq = q32; sr = r32; ok = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (!ovl32 || ir32 || q32 !== sq || r32 !== sr) ok = 1'b0;
        end
        $display("stall: 50 / 3 -> q=%h r=%h held 10 cycles", sq, sr);
        chk("stall_stable", ok, 1);
        chk("stall_q", sq, 32'd16);
        chk("stall_r", sr, 32'd2);
        or32 = 1'b1; dd32 = 32'd9; ds32 = 32'd2; is32 = 1'b0; iv32 = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready", ir32, 1);
        chk("release_out_valid", ovl32, 0);
        or32 = 1'b0;
        @(posedge clk); #1;
        chk("b2b_accepted", ir32, 0);
        iv32 = 1'b0;
        n = 0;
        while (!ovl32 && n < 100) begin @(posedge clk); #1; n++; end
        $display("b2b: 9 / 2 -> q=%h r=%h", q32, r32);
        chk("b2b_q", q32, 32'd4);
        chk("b2b_r", r32, 32'd1);
        or32 = 1'b1;
        @(posedge clk); #1;
        or32 = 1'b0;

        // Reset during CALC cycle 10
        @(negedge clk);
        dd32 = 32'd100; ds32 = 32'd7; is32 = 1'b0; iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", ir32, 1);
        chk("midrst_out_valid", ovl32, 0);
        chk("midrst_quotient", q32, 0);
        chk("midrst_remainder", r32, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_hold_out_valid", ovl32, 0);
        @(negedge clk) rst_n = 1'b1;
        run_op(1'b0, 32'd100, 32'd7, 1'b0, 0, q, r, dz, ov, lat);
        $display("post-reset: 100 / 7 -> q=%h r=%h lat=%0d", q, r, lat);
        chk("postrst_q", q, 32'd14);
        chk("postrst_r", r, 32'd2);
        chk("postrst_lat", lat, 33);

        // WIDTH=8 random regression against the reference model
        for (int i = 0; i < 300; i++) begin
            a = {24'd0, 8'($urandom)};
            b = {24'd0, 8'($urandom)};
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h80; b = 32'hFF; end
                2: b = 32'd1;
                3: b = 32'hFF;
                default: ;
            endcase
            s = 1'($urandom);
            hold = $urandom_range(0, 3);
            run_op(1'b1, a, b, s, hold, q, r, dz, ov, lat);
            ref_div(u64_t'(a), u64_t'(b), s, 8, eq, er, edz, eov);
            $display("rand %0d: %h / %h s=%0b -> q=%h r=%h dz=%0b ov=%0b lat=%0d",
                     i, a[7:0], b[7:0], s, q[7:0], r[7:0], dz, ov, lat);
            chk($sformatf("rand%0d", i),
                {38'd0, q[7:0], r[7:0], dz, ov, 8'(lat)},
                {38'd0, 8'(eq), 8'(er), edz, eov, (edz ? 8'd0 : 8'd9)});
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
